// File: rtl/spec_tran_sched.sv
// -----------------------------------------------------------------------------
// spec_tran_sched
//   AW-channel scheduler placed in front of the downstream slave. It sequences
//   the special transactions that process_mem tracks:
//     * regular AWs pass through, limited by the outstanding-write count and
//       by the process_mem full flag;
//     * a BLOCK AW waits for every outstanding write to complete, issues, and
//       then holds the channel until block_fin;
//     * a DIVERT AW issues normally and then holds the channel until
//       spec_release.
//   Optional build macro: SPEC_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on the
//   DRAIN / BLK_WAIT / DIV_WAIT states. On expiry it flags err and returns to
//   PASS.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_awvalid/s_awready/s_awid/s_awuser   upstream AW channel
//   m_awvalid/m_awready/m_awid/m_awuser   downstream AW channel
//   bvalid, bready                B channel, monitored only
//   mem_full                      process_mem full flag
//   block_fin / block_ack         block completion and its one-cycle ack
//   spec_release / release_ready  special release and its one-cycle ack
//   outstanding                   issued writes that have no B response yet
//   state                         PASS=0, DRAIN=1, BLK_WAIT=2, DIV_WAIT=3
//   err                           sticky error flag
// -----------------------------------------------------------------------------
module spec_tran_sched #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
   parameter int TIMEOUT_CYC     = 255,
   parameter int PID_WIDTH       = 4,
   parameter int PAWUSER_WIDTH   = 2,
   parameter logic [PAWUSER_WIDTH-1:0] BLOCK  = PAWUSER_WIDTH'(1),
   parameter logic [PAWUSER_WIDTH-1:0] DIVERT = PAWUSER_WIDTH'(2)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_awvalid,
   output logic                     s_awready,
   input  logic [PID_WIDTH-1:0]     s_awid,
   input  logic [PAWUSER_WIDTH-1:0] s_awuser,
   output logic                     m_awvalid,
   input  logic                     m_awready,
   output logic [PID_WIDTH-1:0]     m_awid,
   output logic [PAWUSER_WIDTH-1:0] m_awuser,
   input  logic                     bvalid,
   input  logic                     bready,
   input  logic                     mem_full,
   input  logic                     block_fin,
   output logic                     block_ack,
   input  logic                     spec_release,
   output logic                     release_ready,
   output logic [CNT_W-1:0]         outstanding,
   output logic [1:0]               state,
   output logic                     err
);

   typedef enum logic [1:0] {
      ST_PASS     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_BLK_WAIT = 2'd2,
      ST_DIV_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                   state_q, state_d, ns_s;
   logic                     hold_valid_q, hold_valid_d;
   logic [PID_WIDTH-1:0]     hold_id_q, hold_id_d;
   logic [PAWUSER_WIDTH-1:0] hold_user_q, hold_user_d;
   logic                     m_awvalid_q, m_awvalid_d;
   logic                     s_awready_q, s_awready_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     block_ack_q, block_ack_d;
   logic                     release_ready_q, release_ready_d;
   logic                     err_q, err_d;

   logic hs_up_s, hs_dn_s, dec_s, issue_ok_s, hold_is_blk_s;
   logic fin_evt_s, rel_evt_s, cnt_err_s, wd_expire_s, blk_bypass_s;

   assign hs_up_s       = s_awvalid & s_awready_q;
   assign hs_dn_s       = m_awvalid_q & m_awready;
   assign dec_s         = bvalid & bready;
   assign hold_is_blk_s = hold_valid_q & (hold_user_q == BLOCK);
   // A level input held high right after its ack is the same event, not a new one.
   assign fin_evt_s     = block_fin & ~block_ack_q;
   assign rel_evt_s     = spec_release & ~release_ready_q & (state_q == ST_DIV_WAIT);

   // Issue permission for the hold-buffer entry. In PASS a BLOCK entry must go
   // through DRAIN first unless the watchdog already gave up on draining.
   always_comb begin
      issue_ok_s = 1'b0;
      case (state_q)
         ST_PASS:  issue_ok_s = (cnt_q < CNT_MAX) & ~mem_full &
                                (~hold_is_blk_s | blk_bypass_s);
         ST_DRAIN: issue_ok_s = (cnt_q == CNT_ZERO) & ~mem_full;
         default:  issue_ok_s = 1'b0;
      endcase
   end

   // Hold buffer and registered downstream valid.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_id_d    = hold_id_q;
      hold_user_d  = hold_user_q;
      m_awvalid_d  = m_awvalid_q;
      if (hs_dn_s) begin
         hold_valid_d = 1'b0;
         m_awvalid_d  = 1'b0;
      end else if (m_awvalid_q) begin
         m_awvalid_d  = 1'b1;
      end else begin
         m_awvalid_d  = hold_valid_q & issue_ok_s;
      end
      if (hs_up_s) begin
         hold_valid_d = 1'b1;
         hold_id_d    = s_awid;
         hold_user_d  = s_awuser;
      end else begin
         hold_id_d    = hold_id_q;
         hold_user_d  = hold_user_q;
      end
   end

   // Outstanding-write counter; saturates at both ends and flags misuse.
   always_comb begin
      cnt_d     = cnt_q;
      cnt_err_s = 1'b0;
      case ({hs_dn_s, dec_s})
         2'b10: begin
            if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            else                 cnt_err_s = 1'b1;
         end
         2'b01: begin
            if (cnt_q == CNT_ZERO) cnt_err_s = 1'b1;
            else                   cnt_d = cnt_q - CNT_ONE;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // FSM next state before any watchdog override.
   always_comb begin
      ns_s = state_q;
      case (state_q)
         ST_PASS: begin
            if (hold_is_blk_s & ~m_awvalid_q & ~blk_bypass_s) ns_s = ST_DRAIN;
            else if (hs_dn_s & (hold_user_q == DIVERT))        ns_s = ST_DIV_WAIT;
            else                                                ns_s = ST_PASS;
         end
         ST_DRAIN: begin
            if (hs_dn_s) ns_s = ST_BLK_WAIT;
            else         ns_s = ST_DRAIN;
         end
         ST_BLK_WAIT: begin
            if (fin_evt_s) ns_s = ST_PASS;
            else           ns_s = ST_BLK_WAIT;
         end
         ST_DIV_WAIT: begin
            if (rel_evt_s) ns_s = ST_PASS;
            else           ns_s = ST_DIV_WAIT;
         end
         default: ns_s = ST_PASS;
      endcase
   end

`ifdef SPEC_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            blk_bypass_q, blk_bypass_d;

   assign wd_expire_s  = (state_q != ST_PASS) & (ns_s == state_q) & (wd_q == WD_LAST);
   assign blk_bypass_s = blk_bypass_q;

   // Watchdog restarts on every state change; a BLOCK abandoned in DRAIN
   // is allowed to issue under PASS rules until it hands off downstream.
   always_comb begin
      wd_d         = wd_q + WD_W'(1);
      blk_bypass_d = blk_bypass_q;
      if ((state_d != state_q) || (state_q == ST_PASS)) wd_d = {WD_W{1'b0}};
      else                                               wd_d = wd_q + WD_W'(1);
      if (hs_dn_s)                                   blk_bypass_d = 1'b0;
      else if (wd_expire_s && state_q == ST_DRAIN)   blk_bypass_d = 1'b1;
      else                                           blk_bypass_d = blk_bypass_q;
   end

   // Watchdog registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q         <= {WD_W{1'b0}};
         blk_bypass_q <= 1'b0;
      end else begin
         wd_q         <= wd_d;
         blk_bypass_q <= blk_bypass_d;
      end
   end
`else
   // The watchdog limit has no consumer when the watchdog is not built in.
   logic [31:0] timeout_cyc_unused;
   assign timeout_cyc_unused = TIMEOUT_CYC;
   assign wd_expire_s        = 1'b0;
   assign blk_bypass_s       = 1'b0;
`endif

   // Final state, acks, error and upstream ready, all computed for registering.
   always_comb begin
      state_d = ns_s;
      if (wd_expire_s) state_d = ST_PASS;
      else             state_d = ns_s;
      block_ack_d     = fin_evt_s;
      release_ready_d = rel_evt_s;
      err_d           = err_q | cnt_err_s | wd_expire_s |
                        (fin_evt_s & (state_q != ST_BLK_WAIT));
      s_awready_d     = ~hold_valid_d & (state_d == ST_PASS);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_PASS;
         hold_valid_q    <= 1'b0;
         hold_id_q       <= {PID_WIDTH{1'b0}};
         hold_user_q     <= {PAWUSER_WIDTH{1'b0}};
         m_awvalid_q     <= 1'b0;
         s_awready_q     <= 1'b0;
         cnt_q           <= CNT_ZERO;
         block_ack_q     <= 1'b0;
         release_ready_q <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         hold_valid_q    <= hold_valid_d;
         hold_id_q       <= hold_id_d;
         hold_user_q     <= hold_user_d;
         m_awvalid_q     <= m_awvalid_d;
         s_awready_q     <= s_awready_d;
         cnt_q           <= cnt_d;
         block_ack_q     <= block_ack_d;
         release_ready_q <= release_ready_d;
         err_q           <= err_d;
      end
   end

   assign s_awready     = s_awready_q;
   assign m_awvalid     = m_awvalid_q;
   assign m_awid        = hold_id_q;
   assign m_awuser      = hold_user_q;
   assign block_ack     = block_ack_q;
   assign release_ready = release_ready_q;
   assign outstanding   = cnt_q;
   assign state         = state_q;
   assign err           = err_q;

endmodule

// File: tb/tb_spec_tran_sched.sv
// -----------------------------------------------------------------------------
// tb_spec_tran_sched
//   Self-checking bench for spec_tran_sched. Regular traffic is driven from a
//   vector table; BLOCK, DIVERT, limit, reset and watchdog behaviour use short
//   hand-written sequences. Downstream AWs are checked against a queue of the
//   ids/types that were accepted upstream.
// -----------------------------------------------------------------------------
module tb_spec_tran_sched;

   localparam logic [1:0] U_REG0   = 2'd0;
   localparam logic [1:0] U_BLOCK  = 2'd1;
   localparam logic [1:0] U_DIVERT = 2'd2;
   localparam logic [1:0] U_REG3   = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_awvalid, s_awready;
   logic [3:0] s_awid;
   logic [1:0] s_awuser;
   logic       m_awvalid, m_awready;
   logic [3:0] m_awid;
   logic [1:0] m_awuser;
   logic       bvalid, bready, mem_full;
   logic       block_fin, block_ack, spec_release, release_ready;
   logic [3:0] outstanding;
   logic [1:0] state;
   logic       err;

   always #5 clk = ~clk;

   spec_tran_sched #(
      .MAX_OUTSTANDING(8),
      .TIMEOUT_CYC    (16),
      .PID_WIDTH      (4),
      .PAWUSER_WIDTH  (2),
      .BLOCK          (U_BLOCK),
      .DIVERT         (U_DIVERT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_awvalid    (s_awvalid),
      .s_awready    (s_awready),
      .s_awid       (s_awid),
      .s_awuser     (s_awuser),
      .m_awvalid    (m_awvalid),
      .m_awready    (m_awready),
      .m_awid       (m_awid),
      .m_awuser     (m_awuser),
      .bvalid       (bvalid),
      .bready       (bready),
      .mem_full     (mem_full),
      .block_fin    (block_fin),
      .block_ack    (block_ack),
      .spec_release (spec_release),
      .release_ready(release_ready),
      .outstanding  (outstanding),
      .state        (state),
      .err          (err)
   );

   int         n_vec  = 0;
   int         n_fail = 0;
   logic [5:0] sb_q[$];

   typedef struct {
      logic       do_aw;
      logic [3:0] id;
      logic [1:0] user;
      int         nb;
      logic [3:0] exp_out;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [1:0] user);
      int n = 0;
      while (!s_awready && n < 60) begin
         tick();
         n++;
      end
      if (!s_awready) begin
         check("s_awready_timeout", 32'(s_awready), 32'(1));
      end else begin
         s_awvalid = 1'b1;
         s_awid    = id;
         s_awuser  = user;
         sb_q.push_back({user, id});
         tick();
         s_awvalid = 1'b0;
      end
   endtask

   task automatic wait_issued();
      int n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0) check("issue_timeout", 32'(sb_q.size()), 32'(0));
   endtask

   task automatic wait_state(input logic [1:0] s);
      int n = 0;
      while (state != s && n < 30) begin
         tick();
         n++;
      end
      if (state != s) check("state_timeout", 32'(state), 32'(s));
   endtask

   task automatic wait_mvalid();
      int n = 0;
      while (!m_awvalid && n < 20) begin
         tick();
         n++;
      end
      if (!m_awvalid) check("m_awvalid_timeout", 32'(m_awvalid), 32'(1));
   endtask

   task automatic b_resp(input int n);
      bvalid = 1'b1;
      bready = 1'b1;
      repeat (n) tick();
      bvalid = 1'b0;
      bready = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({s_awready, m_awvalid, m_awid, m_awuser, block_ack,
                       release_ready, outstanding, state, err}), 32'(0));
   endtask

   // Scoreboard: every downstream handshake must match the oldest accepted AW.
   always @(negedge clk) begin
      logic [5:0] e;
      if (rst_n && m_awvalid && m_awready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_m_aw", 32'({m_awuser, m_awid}), 32'hFFFF);
         end else begin
            e = sb_q.pop_front();
            check("m_aw_user_id", 32'({m_awuser, m_awid}), 32'(e));
         end
      end
   end

   // Global time bound.
   initial begin
      #300000;
      $display("FAIL global_timeout: bench did not finish at %0t", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      tbl[0] = '{1'b1, 4'h1, U_REG0, 0, 4'd1};
      tbl[1] = '{1'b1, 4'h2, U_REG3, 0, 4'd2};
      tbl[2] = '{1'b1, 4'h3, U_REG0, 0, 4'd3};
      tbl[3] = '{1'b0, 4'h0, U_REG0, 2, 4'd1};
      tbl[4] = '{1'b1, 4'hA, U_REG3, 1, 4'd1};
      tbl[5] = '{1'b0, 4'h0, U_REG0, 1, 4'd0};

      rst_n = 1'b0; s_awvalid = 1'b0; s_awid = 4'h0; s_awuser = 2'd0;
      m_awready = 1'b1; bvalid = 1'b0; bready = 1'b0; mem_full = 1'b0;
      block_fin = 1'b0; spec_release = 1'b0;

      // Reset state
      #12;
      check_all_zero("reset_outputs");
      rst_n = 1'b1;
      tick();
      check("ready_after_reset", 32'(s_awready), 32'(1));

      // Table of regular traffic and B responses
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].do_aw) begin
            send_aw(tbl[i].id, tbl[i].user);
            wait_issued();
            tick();
         end
         if (tbl[i].nb > 0) b_resp(tbl[i].nb);
         check($sformatf("vec%0d_outstanding", i), 32'(outstanding), 32'(tbl[i].exp_out));
         check($sformatf("vec%0d_state_err", i), 32'({state, err}), 32'(0));
      end

      // Outstanding limit: 8 issued, the 9th waits for one B
      for (int i = 0; i < 8; i++) begin
         send_aw(4'(i), U_REG0);
         wait_issued();
      end
      tick();
      check("limit_outstanding8", 32'(outstanding), 32'(8));
      send_aw(4'hF, U_REG3);
      repeat (5) tick();
      check("limit_9th_blocked", 32'({m_awvalid, s_awready}), 32'(0));
      b_resp(1);
      check("limit_no_issue_yet", 32'(m_awvalid), 32'(0));
      tick();
      check("limit_issue_1_later", 32'(m_awvalid), 32'(1));
      tick();
      check("limit_back_to_8", 32'(outstanding), 32'(8));
      b_resp(8);
      check("limit_drained", 32'(outstanding), 32'(0));

      // BLOCK with two writes outstanding
      send_aw(4'h4, U_REG0); wait_issued();
      send_aw(4'h5, U_REG3); wait_issued();
      send_aw(4'h6, U_BLOCK);
      tick();
      check("blk_drain_state", 32'({state, m_awvalid}), 32'({2'd1, 1'b0}));
      repeat (3) tick();
      check("blk_drain_hold", 32'({state, m_awvalid, outstanding}), 32'({2'd1, 1'b0, 4'd2}));
      b_resp(1);
      check("blk_after_one_b", 32'({state, m_awvalid}), 32'({2'd1, 1'b0}));
      b_resp(1);
      wait_state(2'd2);
      wait_issued();
      check("blk_wait_entry", 32'({s_awready, block_ack, outstanding}), 32'({1'b0, 1'b0, 4'd1}));
      block_fin = 1'b1;
      tick();
      check("blk_ack_pulse", 32'({block_ack, state}), 32'({1'b1, 2'd0}));
      tick();
      check("blk_ack_single", 32'({block_ack, err, state}), 32'(0));
      block_fin = 1'b0;
      b_resp(1);

      // DIVERT
      send_aw(4'h7, U_DIVERT);
      wait_issued();
      tick();
      check("div_wait_state", 32'({state, s_awready}), 32'({2'd3, 1'b0}));
      repeat (3) tick();
      check("div_wait_hold", 32'({state, release_ready}), 32'({2'd3, 1'b0}));
      spec_release = 1'b1;
      tick();
      check("div_release_pulse", 32'({release_ready, s_awready, state}), 32'({1'b1, 1'b1, 2'd0}));
      spec_release = 1'b0;
      tick();
      check("div_release_single", 32'(release_ready), 32'(0));
      b_resp(1);

      // mem_full gates a new issue
      mem_full = 1'b1;
      send_aw(4'h8, U_REG0);
      repeat (4) tick();
      check("memfull_blocks", 32'(m_awvalid), 32'(0));
      mem_full = 1'b0;
      wait_issued();
      tick();
      check("memfull_released", 32'(outstanding), 32'(1));

      // Same-cycle AW and B handshakes at outstanding=4
      for (int i = 0; i < 3; i++) begin
         send_aw(4'(9 + i), U_REG3);
         wait_issued();
      end
      m_awready = 1'b0;
      send_aw(4'hC, U_REG0);
      wait_mvalid();
      mem_full = 1'b1;
      tick();
      check("valid_sticky_memfull", 32'({m_awvalid, outstanding}), 32'({1'b1, 4'd4}));
      mem_full = 1'b0; m_awready = 1'b1; bvalid = 1'b1; bready = 1'b1;
      tick();
      bvalid = 1'b0; bready = 1'b0;
      check("same_cycle_aw_b", 32'({m_awvalid, outstanding}), 32'({1'b0, 4'd4}));
      b_resp(4);

      // spec_release outside DIV_WAIT is ignored
      spec_release = 1'b1;
      tick();
      spec_release = 1'b0;
      check("release_outside", 32'({release_ready, err, state}), 32'(0));

`ifdef SPEC_TIMEOUT_EN
      // Watchdog in BLK_WAIT with no block_fin
      send_aw(4'hD, U_BLOCK);
      wait_state(2'd2);
      wait_issued();
      check("wd_entry", 32'({state, err}), 32'({2'd2, 1'b0}));
      repeat (15) tick();
      check("wd_not_yet", 32'(state), 32'(2));
      tick();
      check("wd_expired", 32'({state, err}), 32'({2'd0, 1'b1}));
      b_resp(1);
`endif

      // block_fin outside BLK_WAIT: ack still pulses, err latches
      block_fin = 1'b1;
      tick();
      block_fin = 1'b0;
      check("fin_outside_ack", 32'({block_ack, err}), 32'({1'b1, 1'b1}));
      tick();
      check("fin_outside_sticky", 32'({block_ack, err}), 32'({1'b0, 1'b1}));

      // Reset in the middle of a downstream handshake
      m_awready = 1'b0;
      send_aw(4'hE, U_REG3);
      wait_mvalid();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset_midxfer");
      sb_q.delete();
      m_awready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_reset", 32'({s_awready, m_awvalid, state, outstanding, err}), 32'({1'b1, 1'b0, 2'd0, 4'd0, 1'b0}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
